// File: rtl/program_loader.sv
// program_loader: writer side of the CPU instruction stream.
// Packs an incoming byte stream big-endian into 32-bit words and writes them
// to consecutive instruction-memory word addresses. It holds the CPU stopped
// until a halt word (op 6'b111111) has been written or memory is full.
//
// Optional feature macro: CHECKSUM_EN. When defined, a trailing checksum byte
// (XOR of all program bytes) is checked before the CPU is released.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   rx_data/valid    incoming program byte and its valid
//   rx_ready         byte accepted this cycle when rx_valid is also high
//   reload           restart a load (honoured in RUN/ERR only)
//   im_we/addr/wdata instruction-memory write port (1-cycle write pulse)
//   word_cnt         words written since the last load start
//   cpu_run          CPU may fetch/execute
//   load_done        load finished successfully
//   err              checksum failure (tied 0 without CHECKSUM_EN)
module program_loader #(
  parameter int unsigned IM_AW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             reload,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic [IM_AW:0]   word_cnt,
  output logic             cpu_run,
  output logic             load_done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_WRITE = 3'd1,
    S_RUN   = 3'd2,
    S_CHK   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic        accept_c;
  logic        halt_c;
  logic        full_c;

  assign accept_c = rx_valid & rx_ready;
  assign halt_c   = (im_wdata[31:26] == 6'b111111);
  // Last address reached: the write in progress fills the final slot.
  assign full_c   = &word_cnt[IM_AW-1:0];

`ifdef CHECKSUM_EN
  logic [7:0] xor_acc;
`else
  assign err = 1'b0;
`endif

  // Loader state machine; all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      byte_idx  <= 2'd0;
      word_buf  <= 24'd0;
      rx_ready  <= 1'b1;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= 32'd0;
      word_cnt  <= '0;
      cpu_run   <= 1'b0;
      load_done <= 1'b0;
`ifdef CHECKSUM_EN
      xor_acc   <= 8'd0;
      err       <= 1'b0;
`endif
    end else begin
      im_we <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept_c) begin
            byte_idx <= byte_idx + 2'd1;
            word_buf <= {word_buf[15:0], rx_data};
`ifdef CHECKSUM_EN
            xor_acc  <= xor_acc ^ rx_data;
`endif
            // Fourth byte completes the word: present it on the write port now.
            if (byte_idx == 2'd3) begin
              state    <= S_WRITE;
              rx_ready <= 1'b0;
              im_we    <= 1'b1;
              im_addr  <= word_cnt[IM_AW-1:0];
              im_wdata <= {word_buf, rx_data};
            end
          end
        end

        S_WRITE: begin
          word_cnt <= word_cnt + (IM_AW+1)'(1);
          if (halt_c || full_c) begin
`ifdef CHECKSUM_EN
            state    <= S_CHK;
            rx_ready <= 1'b1;
`else
            state     <= S_RUN;
            cpu_run   <= 1'b1;
            load_done <= 1'b1;
`endif
          end else begin
            state    <= S_LOAD;
            rx_ready <= 1'b1;
          end
        end

        S_RUN: begin
          if (reload) begin
            state     <= S_LOAD;
            byte_idx  <= 2'd0;
            word_cnt  <= '0;
            rx_ready  <= 1'b1;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
`ifdef CHECKSUM_EN
            xor_acc   <= 8'd0;
`endif
          end
        end

`ifdef CHECKSUM_EN
        S_CHK: begin
          if (accept_c) begin
            rx_ready <= 1'b0;
            if (rx_data == xor_acc) begin
              state     <= S_RUN;
              cpu_run   <= 1'b1;
              load_done <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end

        S_ERR: begin
          if (reload) begin
            state     <= S_LOAD;
            byte_idx  <= 2'd0;
            word_cnt  <= '0;
            rx_ready  <= 1'b1;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
            xor_acc   <= 8'd0;
            err       <= 1'b0;
          end
        end
`endif

        default: begin
          state    <= S_LOAD;
          byte_idx <= 2'd0;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: two instances (IM_AW=8 and IM_AW=2), a
// vector table, hand-written corner sequences and randomized programs checked
// against a word-level model of the load rules.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data  [2];
  logic       rx_valid [2];
  logic       reload   [2];

  logic        a_rx_ready, a_im_we, a_cpu_run, a_load_done, a_err;
  logic [7:0]  a_im_addr;
  logic [31:0] a_im_wdata;
  logic [8:0]  a_word_cnt;

  logic        b_rx_ready, b_im_we, b_cpu_run, b_load_done, b_err;
  logic [1:0]  b_im_addr;
  logic [31:0] b_im_wdata;
  logic [2:0]  b_word_cnt;

  program_loader #(.IM_AW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(a_rx_ready), .reload(reload[0]), .im_we(a_im_we),
    .im_addr(a_im_addr), .im_wdata(a_im_wdata), .word_cnt(a_word_cnt),
    .cpu_run(a_cpu_run), .load_done(a_load_done), .err(a_err)
  );

  program_loader #(.IM_AW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(b_rx_ready), .reload(reload[1]), .im_we(b_im_we),
    .im_addr(b_im_addr), .im_wdata(b_im_wdata), .word_cnt(b_word_cnt),
    .cpu_run(b_cpu_run), .load_done(b_load_done), .err(b_err)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] wr_a[$];
  logic [63:0] wr_b[$];
  logic [7:0]  prog[$];
  logic [31:0] exp_words[$];

  // Record every memory write as {addr, data}.
  always @(negedge clk) begin
    if (a_im_we) wr_a.push_back({32'(a_im_addr), a_im_wdata});
    if (b_im_we) wr_b.push_back({32'(b_im_addr), b_im_wdata});
  end

  typedef struct {
    logic [31:0] word;
    int          gap;
    logic [31:0] exp_addr;
    logic        exp_run;
    int          exp_cnt;
  } vec_t;
  vec_t vecs[5];

  function automatic logic get_ready(input int d);
    return (d == 0) ? a_rx_ready : b_rx_ready;
  endfunction
  function automatic logic get_run(input int d);
    return (d == 0) ? a_cpu_run : b_cpu_run;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? a_load_done : b_load_done;
  endfunction
  function automatic int get_cnt(input int d);
    return (d == 0) ? 32'(a_word_cnt) : 32'(b_word_cnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    rx_data[d]  = b;
    rx_valid[d] = 1'b1;
    n = 0;
    while (!get_ready(d) && n < 50) begin
      tick();
      n++;
    end
    if (!get_ready(d)) begin
      tests++;
      fails++;
      $display("FAIL send_timeout dut%0d: got rx_ready 0 expected 1", d);
    end
    tick();
    rx_valid[d] = 1'b0;
  endtask

  task automatic do_reload(input int d);
    reload[d] = 1'b1;
    tick();
    reload[d] = 1'b0;
    check("reload_run", 64'(get_run(d)), 64'd0);
    check("reload_done", 64'(get_done(d)), 64'd0);
    check("reload_cnt", 64'(get_cnt(d)), 64'd0);
    check("reload_ready", 64'(get_ready(d)), 64'd1);
  endtask

  // Expected writes: big-endian words, ending after a halt word or a full memory.
  task automatic model(input int cap);
    logic [31:0] w;
    exp_words.delete();
    for (int i = 0; 4 * i + 3 < prog.size(); i++) begin
      w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
      exp_words.push_back(w);
      if (w[31:26] == 6'b111111 || exp_words.size() == cap) break;
    end
  endtask

  // Load `prog` into DUT d and compare writes and final status with the model.
  task automatic load_and_check(input int d, input int glo, input int ghi, input string name);
    logic [7:0]  chk;
    logic [63:0] ent;
    int          nw;
    model((d == 0) ? 256 : 4);
    if (d == 0) wr_a.delete(); else wr_b.delete();
    chk = 8'd0;
    for (int j = 0; j < 4 * exp_words.size(); j++) begin
      send_byte(d, prog[j], int'($urandom_range(ghi, glo)));
      chk = chk ^ prog[j];
    end
`ifdef CHECKSUM_EN
    send_byte(d, chk, 0);
`endif
    tick();
    tick();
    nw = (d == 0) ? wr_a.size() : wr_b.size();
    check({name, "_nwrites"}, 64'(nw), 64'(exp_words.size()));
    for (int i = 0; i < nw && i < exp_words.size(); i++) begin
      ent = (d == 0) ? wr_a[i] : wr_b[i];
      check({name, "_write"}, ent, {32'(i), exp_words[i]});
    end
    check({name, "_cnt"}, 64'(get_cnt(d)), 64'(exp_words.size()));
    check({name, "_run"}, 64'(get_run(d)), 64'd1);
    check({name, "_done"}, 64'(get_done(d)), 64'd1);
    check({name, "_ready"}, 64'(get_ready(d)), 64'd0);
  endtask

  task automatic set_prog_test1();
    prog.delete();
    prog = '{8'h24, 8'h09, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  tab_x;
    int          nw;

    vecs[0] = '{32'h24090005, 0, 32'd0, 1'b0, 1};
    vecs[1] = '{32'h8C010004, 2, 32'd1, 1'b0, 2};
    vecs[2] = '{32'h00000000, 1, 32'd2, 1'b0, 3};
    vecs[3] = '{32'hFBFFFFFF, 0, 32'd3, 1'b0, 4};
    vecs[4] = '{32'hFC000001, 3, 32'd4, 1'b1, 5};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rx_data[d] = 8'd0; rx_valid[d] = 1'b0; reload[d] = 1'b0;
    end
    tick();
    tick();
    check("rst_ready", 64'(a_rx_ready), 64'd1);
    check("rst_we", 64'(a_im_we), 64'd0);
    check("rst_addr", 64'(a_im_addr), 64'd0);
    check("rst_wdata", 64'(a_im_wdata), 64'd0);
    check("rst_cnt", 64'(a_word_cnt), 64'd0);
    check("rst_run", 64'(a_cpu_run), 64'd0);
    check("rst_done", 64'(a_load_done), 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_b_ready", 64'(b_rx_ready), 64'd1);
    check("rst_b_cnt", 64'(b_word_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Vector table: one word per record, write port checked in the WRITE cycle.
    tab_x = 8'd0;
    for (int i = 0; i < 5; i++) begin
      w = vecs[i].word;
      for (int k = 0; k < 4; k++) begin
        send_byte(0, w[31-8*k -: 8], vecs[i].gap);
        tab_x = tab_x ^ w[31-8*k -: 8];
      end
      check("vec_we", 64'(a_im_we), 64'd1);
      check("vec_addr", 64'(a_im_addr), 64'(vecs[i].exp_addr));
      check("vec_wdata", 64'(a_im_wdata), 64'(w));
      tick();
      if (vecs[i].exp_run) begin
`ifdef CHECKSUM_EN
        send_byte(0, tab_x, 0);
`endif
        check("vec_run", 64'(a_cpu_run), 64'd1);
        check("vec_done", 64'(a_load_done), 64'd1);
      end else begin
        check("vec_run", 64'(a_cpu_run), 64'd0);
        check("vec_ready", 64'(a_rx_ready), 64'd1);
        check("vec_we_low", 64'(a_im_we), 64'd0);
        check("vec_hold", 64'(a_im_wdata), 64'(w));
      end
      check("vec_cnt", 64'(a_word_cnt), 64'(vecs[i].exp_cnt));
    end

    // Reload from RUN, then the reference program without and with gaps.
    do_reload(0);
    set_prog_test1();
    load_and_check(0, 0, 0, "t1");
    do_reload(0);
    set_prog_test1();
    load_and_check(0, 1, 3, "t2_gaps");

    // Reset mid-word discards the partial word.
    do_reload(0);
    send_byte(0, 8'h8C, 0);
    send_byte(0, 8'h01, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_a.delete();
    send_byte(0, 8'h24, 0);
    send_byte(0, 8'h09, 1);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h05, 2);
    tick();
    check("t3_nwrites", 64'(wr_a.size()), 64'd1);
    if (wr_a.size() > 0) check("t3_write", wr_a[0], {32'd0, 32'h24090005});
    check("t3_cnt", 64'(a_word_cnt), 64'd1);
    check("t3_run", 64'(a_cpu_run), 64'd0);

    // reload during LOAD is ignored: the word in progress continues.
    send_byte(0, 8'h8C, 0);
    send_byte(0, 8'h01, 0);
    reload[0] = 1'b1;
    tick();
    reload[0] = 1'b0;
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h04, 0);
    tick();
    check("ld_reload_nwrites", 64'(wr_a.size()), 64'd2);
    if (wr_a.size() > 1) check("ld_reload_write", wr_a[1], {32'd1, 32'h8C010004});
    check("ld_reload_cnt", 64'(a_word_cnt), 64'd2);

    // Full memory on the small instance: four writes, no wrap, later bytes refused.
    prog.delete();
    repeat (20) prog.push_back(8'h00);
    load_and_check(1, 0, 1, "t4_full");
    rx_data[1] = 8'hAA;
    rx_valid[1] = 1'b1;
    repeat (5) tick();
    check("t4_ready_low", 64'(b_rx_ready), 64'd0);
    rx_valid[1] = 1'b0;
    tick();
    check("t4_no_extra", 64'(wr_b.size()), 64'd4);
    check("t4_cnt", 64'(b_word_cnt), 64'd4);

    // Checksum failure path, or err stuck low without the feature.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef CHECKSUM_EN
    set_prog_test1();
    for (int j = 0; j < 8; j++) send_byte(0, prog[j], 0);
    send_byte(0, 8'hD5, 0);
    check("t5_err", 64'(a_err), 64'd1);
    check("t5_run", 64'(a_cpu_run), 64'd0);
    check("t5_ready", 64'(a_rx_ready), 64'd0);
    reload[0] = 1'b1;
    tick();
    reload[0] = 1'b0;
    check("t5_err_clr", 64'(a_err), 64'd0);
    check("t5_cnt", 64'(a_word_cnt), 64'd0);
    check("t5_ready_load", 64'(a_rx_ready), 64'd1);
`else
    check("err_tied", 64'(a_err), 64'd0);
`endif

    // Randomized programs on both instances.
    for (int it = 0; it < 16; it++) begin
      int d;
      int n;
      d = it % 2;
      if (get_run(d)) do_reload(d);
      prog.delete();
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if ($urandom_range(3, 0) == 0) w[31:26] = 6'b111111;
        else if (w[31:26] == 6'b111111) w[26] = 1'b0;
        if (i == n - 1) w[31:26] = 6'b111111;
        for (int k = 0; k < 4; k++) prog.push_back(w[31-8*k -: 8]);
      end
      load_and_check(d, 0, 2, "rand");
    end

    nw = wr_a.size();
    check("err_b_low", 64'(b_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
